if_id_buf: RTL and testbench
============================

Name: if_id_buf

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- A DEPTH-entry FIFO of {pc, inst} pairs sits between IF and ID, so fetch can run ahead while ID is stalled.
- Keeps the existing stall-bus and flush semantics: flush clears everything, and a stalled-IF/running-ID condition yields a NOP bubble.
- Exports a full flag that ctrl folds into the IF stall request.

Parameters:
- ADDR_W, 32, pc width.
- INST_W, 32, instruction width.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- STALL_W, 6, width of the stall bus from ctrl.
- IF_IDX, 1, stall-bus bit that stops IF.
- ID_IDX, 2, stall-bus bit that stops ID.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- stall  in  STALL_W  per-stage stop bits from ctrl; 1 = Stop.
- flush  in  1  exception/interrupt flush.
- if_valid  in  1  IF presents a fetched instruction this cycle.
- if_pc  in  ADDR_W  pc of the fetched instruction.
- if_inst  in  INST_W  fetched instruction.
- buf_full  out  1  combinational; count == DEPTH.
- buf_count  out  clog2(DEPTH)+1  current occupancy, registered.
- id_valid  out  1  id_pc/id_inst hold a real instruction.
- id_pc  out  ADDR_W  pc to ID.
- id_inst  out  INST_W  instruction to ID; 0 means NOP.

Behaviour:
- Reset (rst = 0, async): rd_ptr, wr_ptr and count go to 0. id_pc, id_inst, id_valid go to 0. buf_full = 0.
- push = if_valid & ~stall[IF_IDX] & ~buf_full.
  - buf_full is evaluated on pre-edge count, so no push while full even if a pop happens the same edge.
  - Write at wr_ptr; wr_ptr wraps modulo DEPTH.
- Output register, evaluated each rising edge in priority order:
  1. flush = 1:
     - id_* <= 0, id_valid <= 0.
     - Pointers and count <= 0.
     - Any same-edge push is discarded.
  2. stall[ID_IDX] = Stop:
     - id_* hold.
     - No pop; push still permitted.
  3. ID running and count > 0:
     - id_* <= entry[rd_ptr], id_valid <= 1.
     - Pop: rd_ptr++, with wrap.
  4. ID running and count == 0: bubble; id_* <= 0, id_valid <= 0.
- count update: count + push - pop. Push and pop on the same edge leave count unchanged.
- Latency: an entry pushed at edge N can appear on id_* no earlier than edge N+1.
- Throughput: one instruction per cycle when steady (count ≥ 1, no stalls).
- Wrap-around: pointers are clog2(DEPTH) bits and roll over silently. count alone distinguishes full from empty.
- Reset asserted mid-operation: all state clears immediately and asynchronously. No partial entries survive.
- Entry storage (data array) has no reset; only pointers, count and outputs reset.

Optional Feature:
- Macro: IF_ID_BYPASS_EN.
- When defined: if count == 0, ID is running, no flush, and push would occur, then at that edge:
  - id_* <= {if_pc, if_inst}, id_valid <= 1.
  - The entry is not written and count is unchanged.
  - Empty-buffer latency becomes 0 extra cycles, matching the legacy single-register timing.
- When undefined: the instruction is written to the FIFO, producing a bubble that edge; min fetch-to-ID latency is 1 extra cycle.
- All other rules are identical in both builds.

Decomposition:
- Shared defines file (existing `include):
  - Stop/NotStop values.
  - ZeroWord / NOP encoding.
  - Default widths (InstAddrBus, InstBus, StallBus).
- New constant IfIdBufDepth goes into the same defines file.
- One natural sub-module: if_id_fifo_mem.
  - Parametrised DEPTH × (ADDR_W+INST_W) register array.
  - Synchronous write port, asynchronous read at rd_ptr.
- Pointer, count and output control stay in if_id_buf.

Test Plan:
- Reset then idle: rst = 0 for 3 cycles with if_valid = 1 → id_inst = 0, id_valid = 0, buf_count = 0 throughout; after release the first push is accepted.
- Steady stream: push pc 0x100, 0x104, 0x108 on consecutive edges, no stalls → id_pc sequence 0x100, 0x104, 0x108, one edge after each push (same edge with IF_ID_BYPASS_EN), id_valid = 1.
- ID stall fills buffer: stall[2] = 1 for 6 cycles while pushing 0x200 onward → buf_count reaches 4 and buf_full = 1. The 5th push is refused. id_* hold. On release, pc 0x200..0x20C drain in order.
- Wrap-around: 10 push/pop cycles with DEPTH = 4 at count = 2 → pointer rollover with order preserved, no lost or duplicated pc.
- Flush while full: count = 4, flush = 1 with simultaneous push of 0x300 → next edge count = 0, id_inst = 0, id_valid = 0, and 0x300 never appears.
- IF stalled, ID running: stall = 6'b000010 with count = 0 → id_inst = 0 bubble each cycle, no push even with if_valid = 1.

Source files
------------

// File: rtl/if_id_buf_pkg.sv
// Shared constants and types for the IF/ID instruction buffer.
// Replaces the legacy defines: stall polarity, zero/NOP words, default bus widths.
package if_id_buf_pkg;

    localparam logic        Stop         = 1'b1;
    localparam logic        NotStop      = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [31:0] NopInst      = 32'h0000_0000;
    localparam int          InstAddrBus  = 32;
    localparam int          InstBus      = 32;
    localparam int          StallBus     = 6;
    localparam int          IfIdBufDepth = 4;

    typedef enum logic [1:0] {
        OUT_HOLD,
        OUT_LOAD,
        OUT_BUBBLE,
        OUT_FLUSH
    } out_sel_e;

endpackage

// File: rtl/if_id_buf_if.sv
// Bus between IF, ctrl and ID around the IF/ID buffer.
// master = surrounding pipeline (drives stall/flush/fetch), slave = the buffer.
interface if_id_buf_if
    import if_id_buf_pkg::*;
#(
    parameter int ADDR_W  = InstAddrBus,
    parameter int INST_W  = InstBus,
    parameter int DEPTH   = IfIdBufDepth,
    parameter int STALL_W = StallBus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               if_valid;
    logic [ADDR_W-1:0]  if_pc;
    logic [INST_W-1:0]  if_inst;
    logic               buf_full;
    logic [CNT_W-1:0]   buf_count;
    logic               id_valid;
    logic [ADDR_W-1:0]  id_pc;
    logic [INST_W-1:0]  id_inst;

    modport master (
        output stall, flush, if_valid, if_pc, if_inst,
        input  buf_full, buf_count, id_valid, id_pc, id_inst
    );

    modport slave (
        input  stall, flush, if_valid, if_pc, if_inst,
        output buf_full, buf_count, id_valid, id_pc, id_inst
    );

endinterface

// File: rtl/if_id_fifo_mem.sv
// Entry storage for the IF/ID buffer: synchronous write, asynchronous read.
// Deliberately unreset; validity is tracked by the pointers and count in the top.
module if_id_fifo_mem #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_buf.sv
// IF/ID pipeline buffer: DEPTH-entry FIFO of {pc, inst} with flush and NOP bubbles.
// Optional macro IF_ID_BYPASS_EN forwards a fetch straight to ID when the FIFO is empty.
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter int ADDR_W  = InstAddrBus,
    parameter int INST_W  = InstBus,
    parameter int DEPTH   = IfIdBufDepth,
    parameter int STALL_W = StallBus,
    parameter int IF_IDX  = 1,
    parameter int ID_IDX  = 2
) (
    input logic         clk,
    input logic         rst,
    if_id_buf_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + INST_W;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;
    logic [ENT_W-1:0]  rd_entry;
    logic              full, push, id_run, bypass, wr_en, pop;
    out_sel_e          out_sel;

    // full uses the pre-edge count, so a same-edge pop never frees room for a push
    assign full   = (count_q == CNT_W'(DEPTH));
    assign push   = bus.if_valid && (bus.stall[IF_IDX] == NotStop) && !full;
    assign id_run = (bus.stall[ID_IDX] == NotStop);

`ifdef IF_ID_BYPASS_EN
    assign bypass = push && id_run && !bus.flush && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        out_sel = OUT_HOLD;
        if (bus.flush) begin
            out_sel = OUT_FLUSH;
        end else if (bus.stall[ID_IDX] == Stop) begin
            out_sel = OUT_HOLD;
        end else if (count_q != '0) begin
            out_sel = OUT_LOAD;
        end else begin
            out_sel = OUT_BUBBLE;
        end
    end

    always_comb begin
        wr_en      = push && !bus.flush && !bypass;
        pop        = (out_sel == OUT_LOAD);
        wr_ptr_d   = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(wr_en) - CNT_W'(pop);
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        unique case (out_sel)
            OUT_FLUSH: begin
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                count_d    = '0;
                id_valid_d = 1'b0;
                id_pc_d    = ADDR_W'(ZeroWord);
                id_inst_d  = INST_W'(NopInst);
            end
            OUT_LOAD: begin
                id_valid_d           = 1'b1;
                {id_pc_d, id_inst_d} = rd_entry;
            end
            OUT_BUBBLE: begin
                if (bypass) begin
                    id_valid_d = 1'b1;
                    id_pc_d    = bus.if_pc;
                    id_inst_d  = bus.if_inst;
                end else begin
                    id_valid_d = 1'b0;
                    id_pc_d    = ADDR_W'(ZeroWord);
                    id_inst_d  = INST_W'(NopInst);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= ADDR_W'(ZeroWord);
            id_inst_q  <= INST_W'(NopInst);
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
        end
    end

    if_id_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata ({bus.if_pc, bus.if_inst}),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    assign bus.buf_full  = full;
    assign bus.buf_count = count_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.id_pc     = id_pc_q;
    assign bus.id_inst   = id_inst_q;

endmodule

// File: tb/tb_if_id_buf.sv
// Directed bench for if_id_buf (DEPTH = 4); expectations follow IF_ID_BYPASS_EN when defined.
module tb_if_id_buf;
    import if_id_buf_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int INST_W  = 32;
    localparam int DEPTH   = 4;
    localparam int STALL_W = 6;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    if_id_buf_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .STALL_W(STALL_W)) bus ();

    if_id_buf #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH),
        .STALL_W(STALL_W), .IF_IDX(1), .ID_IDX(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'hE000_0000 | pc;
    endfunction

    // {id_valid, id_pc, id_inst, buf_count, buf_full}
    function automatic logic [68:0] exp_of(input logic v, input logic [31:0] pc,
                                           input int cnt, input logic full);
        return {v, (v ? pc : 32'h0), (v ? inst_of(pc) : 32'h0), 3'(cnt), full};
    endfunction

    function automatic logic [68:0] obs();
        return {bus.id_valid, bus.id_pc, bus.id_inst, bus.buf_count, bus.buf_full};
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc);
        bus.if_valid = v;
        bus.if_pc    = pc;
        bus.if_inst  = inst_of(pc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [68:0] e1, e2;
        rst       = 1'b0;
        bus.stall = '0;
        bus.flush = 1'b0;
        drive(1'b1, 32'h40);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== exp_of(1'b0, 32'h0, 0, 1'b0))
                $display("FAIL reset[%0d] got %h want %h", i, obs(), exp_of(1'b0, 32'h0, 0, 1'b0));
            else passes++;
        end
`ifdef IF_ID_BYPASS_EN
        e1 = exp_of(1'b1, 32'h40, 0, 1'b0);
        e2 = exp_of(1'b0, 32'h0, 0, 1'b0);
`else
        e1 = exp_of(1'b0, 32'h0, 1, 1'b0);
        e2 = exp_of(1'b1, 32'h40, 0, 1'b0);
`endif
        rst = 1'b1;
        tick();
        checks++;
        if (obs() !== e1) $display("FAIL first_push got %h want %h", obs(), e1);
        else passes++;
        drive(1'b0, 32'h0);
        tick();
        checks++;
        if (obs() !== e2) $display("FAIL first_out got %h want %h", obs(), e2);
        else passes++;
        tick();
    endtask

    task automatic test_stream();
        logic [68:0] e [5];
        logic [31:0] pcs [5];
        logic        vs [5];
        pcs = '{32'h100, 32'h104, 32'h108, 32'h0, 32'h0};
        vs  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef IF_ID_BYPASS_EN
        e = '{exp_of(1'b1, 32'h100, 0, 1'b0), exp_of(1'b1, 32'h104, 0, 1'b0),
              exp_of(1'b1, 32'h108, 0, 1'b0), exp_of(1'b0, 32'h0, 0, 1'b0),
              exp_of(1'b0, 32'h0, 0, 1'b0)};
`else
        e = '{exp_of(1'b0, 32'h0, 1, 1'b0), exp_of(1'b1, 32'h100, 1, 1'b0),
              exp_of(1'b1, 32'h104, 1, 1'b0), exp_of(1'b1, 32'h108, 0, 1'b0),
              exp_of(1'b0, 32'h0, 0, 1'b0)};
`endif
        for (int k = 0; k < 5; k++) begin
            drive(vs[k], pcs[k]);
            tick();
            checks++;
            if (obs() !== e[k]) $display("FAIL stream[%0d] got %h want %h", k, obs(), e[k]);
            else passes++;
        end
    endtask

    task automatic test_stall_fill();
        logic [68:0] e;
        bus.stall = 6'b000100;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * i));
            tick();
            e = exp_of(1'b0, 32'h0, (i >= 3) ? 4 : i + 1, (i >= 3));
            checks++;
            if (obs() !== e) $display("FAIL fill[%0d] got %h want %h", i, obs(), e);
            else passes++;
        end
        // ID released while full: pop happens, push still refused
        bus.stall = '0;
        drive(1'b1, 32'h218);
        tick();
        e = exp_of(1'b1, 32'h200, 3, 1'b0);
        checks++;
        if (obs() !== e) $display("FAIL full_pop got %h want %h", obs(), e);
        else passes++;
        drive(1'b0, 32'h0);
        for (int j = 1; j < 4; j++) begin
            tick();
            e = exp_of(1'b1, 32'h200 + 32'(4 * j), 3 - j, 1'b0);
            checks++;
            if (obs() !== e) $display("FAIL drain[%0d] got %h want %h", j, obs(), e);
            else passes++;
        end
        tick();
        checks++;
        if (obs() !== exp_of(1'b0, 32'h0, 0, 1'b0))
            $display("FAIL drain_end got %h want %h", obs(), exp_of(1'b0, 32'h0, 0, 1'b0));
        else passes++;
    endtask

    task automatic test_wrap();
        logic [68:0] e;
        bus.stall = 6'b000100;
        drive(1'b1, 32'h500);
        tick();
        drive(1'b1, 32'h504);
        tick();
        checks++;
        if (obs() !== exp_of(1'b0, 32'h0, 2, 1'b0))
            $display("FAIL wrap_pre got %h want %h", obs(), exp_of(1'b0, 32'h0, 2, 1'b0));
        else passes++;
        bus.stall = '0;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h508 + 32'(4 * k));
            tick();
            e = exp_of(1'b1, 32'h500 + 32'(4 * k), 2, 1'b0);
            checks++;
            if (obs() !== e) $display("FAIL wrap[%0d] got %h want %h", k, obs(), e);
            else passes++;
        end
        drive(1'b0, 32'h0);
        tick();
        e = exp_of(1'b1, 32'h528, 1, 1'b0);
        checks++;
        if (obs() !== e) $display("FAIL wrap_tail0 got %h want %h", obs(), e);
        else passes++;
        tick();
        e = exp_of(1'b1, 32'h52C, 0, 1'b0);
        checks++;
        if (obs() !== e) $display("FAIL wrap_tail1 got %h want %h", obs(), e);
        else passes++;
        tick();
        e = exp_of(1'b0, 32'h0, 0, 1'b0);
        checks++;
        if (obs() !== e) $display("FAIL wrap_end got %h want %h", obs(), e);
        else passes++;
    endtask

    task automatic test_flush();
        logic [68:0] z;
        z = exp_of(1'b0, 32'h0, 0, 1'b0);
        bus.stall = 6'b000100;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h280 + 32'(4 * i));
            tick();
        end
        checks++;
        if (obs() !== exp_of(1'b0, 32'h0, 4, 1'b1))
            $display("FAIL flush_pre got %h want %h", obs(), exp_of(1'b0, 32'h0, 4, 1'b1));
        else passes++;
        bus.stall = '0;
        bus.flush = 1'b1;
        drive(1'b1, 32'h300);
        tick();
        checks++;
        if (obs() !== z) $display("FAIL flush_full got %h want %h", obs(), z);
        else passes++;
        bus.flush = 1'b0;
        drive(1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs() !== z) $display("FAIL flush_after[%0d] got %h want %h", i, obs(), z);
            else passes++;
        end
        // flush must clear a valid id_* and drop a same-edge push into a non-full buffer
        bus.stall = 6'b000100;
        drive(1'b1, 32'h2E0);
        tick();
        drive(1'b1, 32'h2F0);
        tick();
        bus.stall = '0;
        drive(1'b0, 32'h0);
        tick();
        checks++;
        if (obs() !== exp_of(1'b1, 32'h2E0, 1, 1'b0))
            $display("FAIL flush_pre2 got %h want %h", obs(), exp_of(1'b1, 32'h2E0, 1, 1'b0));
        else passes++;
        bus.flush = 1'b1;
        drive(1'b1, 32'h304);
        tick();
        checks++;
        if (obs() !== z) $display("FAIL flush_push got %h want %h", obs(), z);
        else passes++;
        bus.flush = 1'b0;
        drive(1'b0, 32'h0);
        tick();
        checks++;
        if (obs() !== z) $display("FAIL flush_push_after got %h want %h", obs(), z);
        else passes++;
    endtask

    task automatic test_if_stall();
        logic [68:0] z;
        z = exp_of(1'b0, 32'h0, 0, 1'b0);
        bus.stall = 6'b000010;
        drive(1'b1, 32'h400);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== z) $display("FAIL if_stall[%0d] got %h want %h", i, obs(), z);
            else passes++;
        end
        bus.stall = '0;
        drive(1'b0, 32'h0);
        tick();
        checks++;
        if (obs() !== z) $display("FAIL if_stall_after got %h want %h", obs(), z);
        else passes++;
    endtask

    task automatic test_async_reset();
        logic [68:0] z;
        z = exp_of(1'b0, 32'h0, 0, 1'b0);
        bus.stall = 6'b000100;
        drive(1'b1, 32'h600);
        tick();
        drive(1'b1, 32'h604);
        tick();
        bus.stall = '0;
        drive(1'b0, 32'h0);
        tick();
        checks++;
        if (obs() !== exp_of(1'b1, 32'h600, 1, 1'b0))
            $display("FAIL arst_pre got %h want %h", obs(), exp_of(1'b1, 32'h600, 1, 1'b0));
        else passes++;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs() !== z) $display("FAIL arst_now got %h want %h", obs(), z);
        else passes++;
        #1 rst = 1'b1;
        tick();
        checks++;
        if (obs() !== z) $display("FAIL arst_after got %h want %h", obs(), z);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_fill();
        test_wrap();
        test_flush();
        test_if_stall();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
